// File: rtl/l1_wt_cache.sv
// Direct-mapped write-through L1 cache, one 32-bit word per line, sitting between
// the CPU port and the SDRAM-side bus (start/done handshake, done held 2 cycles).
module l1_wt_cache #(
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned TAG_BITS   = 24 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cache_clear,
  input  logic [23:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic        cpu_we,
  input  logic        cpu_start,
  output logic [31:0] cpu_q,
  output logic        cpu_done,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        mem_start,
  input  logic [31:0] mem_q,
  input  logic        mem_done
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {CLEAR, IDLE, LOOKUP, MEM, DRAIN, RECOVER} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_BITS-1:0]  clr_cnt_q, clr_cnt_d;
  logic                   pend_clr_q, pend_clr_d;
  logic [23:0]            req_addr_q, req_addr_d;
  logic [31:0]            req_data_q, req_data_d;
  logic                   req_we_q, req_we_d;
  logic [31:0]            cpu_q_q, cpu_q_d;
  logic                   cpu_done_q, cpu_done_d;
  logic [23:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            mem_data_q, mem_data_d;
  logic                   mem_we_q, mem_we_d;
  logic                   mem_start_q, mem_start_d;
  logic [LINES-1:0]       valid_q, valid_d;

  logic [TAG_BITS-1:0]    tag_ram  [LINES];
  logic [31:0]            data_ram [LINES];
  logic [TAG_BITS-1:0]    tag_rd_q;
  logic [31:0]            data_rd_q;

  logic                   rd_en;
  logic                   line_we;
  logic [31:0]            line_data;
  logic                   clear_go;
  logic                   hit;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]    req_tag;

  assign req_idx  = req_addr_q[INDEX_BITS-1:0];
  assign req_tag  = req_addr_q[23:INDEX_BITS];
  assign hit      = valid_q[req_idx] && (tag_rd_q == req_tag);
  assign clear_go = cache_clear || pend_clr_q;

  assign cpu_q     = cpu_q_q;
  assign cpu_done  = cpu_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign mem_start = mem_start_q;

  // Tag/data arrays: registered read issued from IDLE, write on first mem_done
  always_ff @(posedge clk) begin
    if (rd_en) begin
      tag_rd_q  <= tag_ram[cpu_addr[INDEX_BITS-1:0]];
      data_rd_q <= data_ram[cpu_addr[INDEX_BITS-1:0]];
    end
    if (line_we) begin
      tag_ram[req_idx]  <= req_tag;
      data_ram[req_idx] <= line_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    pend_clr_d  = pend_clr_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_we_d    = req_we_q;
    cpu_q_d     = cpu_q_q;
    cpu_done_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_we_d    = mem_we_q;
    mem_start_d = mem_start_q;
    valid_d     = valid_q;
    rd_en       = 1'b0;
    line_we     = 1'b0;
    line_data   = req_we_q ? req_data_q : mem_q;

    if (cache_clear && state_q != IDLE) pend_clr_d = 1'b1;

    unique case (state_q)
      CLEAR: begin
        valid_d[clr_cnt_q] = 1'b0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (clear_go) begin
          pend_clr_d = 1'b0;
          clr_cnt_d  = '0;
          state_d    = CLEAR;
        end else if (cpu_start) begin
          req_addr_d = cpu_addr;
          req_data_d = cpu_data;
          req_we_d   = cpu_we;
          rd_en      = 1'b1;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!req_we_q && hit) begin
          cpu_q_d    = data_rd_q;
          cpu_done_d = 1'b1;
          state_d    = RECOVER;
        end else begin
          mem_start_d = 1'b1;
          mem_addr_d  = req_addr_q;
          mem_data_d  = req_data_q;
          mem_we_d    = req_we_q;
          state_d     = MEM;
        end
      end
      MEM: begin
        if (mem_done) begin
          mem_start_d      = 1'b0;
          line_we          = !reset;
          valid_d[req_idx] = 1'b1;
          cpu_q_d          = line_data;
          cpu_done_d       = 1'b1;
          state_d          = DRAIN;
        end
      end
      DRAIN:   if (!mem_done) state_d = IDLE;
      RECOVER: state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Valid bits are left untouched by reset; the CLEAR sweep establishes them
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      pend_clr_q  <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_we_q    <= 1'b0;
      cpu_q_q     <= '0;
      cpu_done_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pend_clr_q  <= pend_clr_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_we_q    <= req_we_d;
      cpu_q_q     <= cpu_q_d;
      cpu_done_q  <= cpu_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      mem_start_q <= mem_start_d;
      valid_q     <= valid_d;
    end
  end

endmodule
